// File: rtl/mem_access_ctrl_if.sv
// Data-memory port between the access controller and the memory.
// The controller drives the request side. The memory answers with a
// single-cycle ack and returns read data in that same cycle.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_ack;
  logic [63:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer that sits between EX/MEM and MEM/WB.
// It takes one load or store from the EX/MEM register and drives it onto
// a variable-latency req/ack memory port. It holds the pipeline in stall
// while the access is outstanding. It returns load data together with
// the destination register. It reports misaligned doubleword accesses
// and accesses that the memory never acknowledges.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16,  // 0 disables the timeout
  parameter int unsigned ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  input  logic [4:0]        rd,
  mem_access_ctrl_if.master mem,
  output logic              stall,
  output logic              load_valid,
  output logic [63:0]       load_data,
  output logic [4:0]        load_rd,
  output logic              misalign_err,
  output logic              timeout_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             access;

  // When both strobes are set, mem_write decides the direction further down.
  assign access = mem_read | mem_write;

  // stall is combinational. A new access freezes the pipeline in the same
  // cycle that it appears in IDLE.
  assign stall = ((state == IDLE) && access) || (state == BUSY);
  assign busy  = (state != IDLE);

  // This block holds the access FSM, the latched request fields and the
  // registered status pulses.
  // NOTE: every register here is assigned with <=, so each branch reads the
  // values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are also cleared on reset. A dropped
      // access then leaves no stale address, data or rd visible on the
      // outputs.
      state         <= IDLE;
      wait_cnt      <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      load_valid    <= 1'b0;
      load_data     <= '0;
      load_rd       <= '0;
      misalign_err  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      // The status outputs are single-cycle pulses unless a branch sets them.
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (access) begin
            if (addr[2:0] == 3'b000) begin
              state         <= BUSY;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= mem_write;
              mem.mem_addr  <= addr;
              mem.mem_wdata <= wdata;
              load_rd       <= rd;
              wait_cnt      <= '0;
            end else begin
              // A misaligned doubleword never reaches the memory.
              state        <= ERR;
              misalign_err <= 1'b1;
            end
          end
        end

        BUSY: begin
          if (mem.mem_ack) begin
            // If ack arrives on the last allowed cycle, the access still
            // completes normally.
            state       <= DONE;
            mem.mem_req <= 1'b0;
            if (!mem.mem_we) begin
              load_data  <= mem.mem_rdata;
              load_valid <= 1'b1;
            end
          end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
            state       <= ERR;
            mem.mem_req <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // EX/MEM still holds the access that was just served. Its inputs are
        // ignored while the pipeline advances.
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-memory accesses issued from the EX/MEM pipeline register onto a variable-latency memory port using a req/ack handshake. While an access is outstanding it asserts stall, which freezes PC, IF/ID, ID/EX and EX/MEM. It returns load data with its destination register, and flags misaligned doubleword accesses and memory timeouts. It sits between the EX/MEM register outputs and the data memory, feeding the MEM/WB register.

Parameters:
TIMEOUT, 16, max cycles in BUSY waiting for mem_ack before aborting; 0 disables the timeout.
ADDR_W, 64, address width.

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset; synchronous, active-high
mem_read  in  1  load request, from EX/MEM
mem_write  in  1  store request, from EX/MEM
addr  in  ADDR_W  access address (ALU result), from EX/MEM
wdata  in  64  store data, from EX/MEM
rd  in  5  load destination register, from EX/MEM
mem_req  out  1  request to memory, registered
mem_we  out  1  1 = store, 0 = load, registered
mem_addr  out  ADDR_W  latched address
mem_wdata  out  64  latched store data
mem_ack  in  1  memory completion, single-cycle pulse
mem_rdata  in  64  load data, valid when mem_ack=1
stall  out  1  pipeline freeze, combinational
load_valid  out  1  one-cycle pulse: load_data/load_rd valid
load_data  out  64  captured load data
load_rd  out  5  captured destination register
misalign_err  out  1  one-cycle pulse: addr[2:0] != 0
timeout_err  out  1  one-cycle pulse: access aborted by timeout
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, BUSY, DONE, ERR. All registers update on the rising edge of clk only.
- Reset (reset=1 at a clk edge, including mid-access): state=IDLE. mem_req, mem_we, load_valid, misalign_err, timeout_err and busy are 0. mem_addr, mem_wdata, load_data, load_rd and the timeout counter are 0. Any in-flight access is dropped without handshake; an ack arriving after reset is ignored.
- access = mem_read | mem_write. If both are 1, the access is treated as a store (mem_write wins).
- stall = (state==IDLE & access) | state==BUSY. stall is 0 in DONE and ERR.
- IDLE:
  - access & addr[2:0]==0 -> BUSY. Latch mem_addr=addr, mem_wdata=wdata, mem_we=mem_write, load_rd=rd. Set mem_req=1 and clear the counter.
  - access & addr[2:0]!=0 -> ERR. No memory request is issued.
  - No access -> stay in IDLE.
  - mem_ack is ignored.
- BUSY:
  - mem_req is held at 1 and the latched fields are held stable.
  - mem_ack=1 -> DONE and mem_req=0. If mem_we=0, capture load_data=mem_rdata and pulse load_valid in DONE.
  - Else the counter increments. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack -> ERR with mem_req=0, and timeout_err pulses in ERR.
  - An ack on the same edge as the timeout wins: the access completes normally.
- DONE: load_valid=1 for loads only. Inputs are ignored, since EX/MEM still holds the served access. Next state is IDLE. Pipeline advances this cycle.
- ERR: exactly one of misalign_err or timeout_err is 1. Next state is IDLE. Pipeline advances this cycle.
- Latency: an access present in IDLE at cycle 0 with ack returned k cycles after mem_req rises produces DONE at cycle k+1. stall is high for k+1 cycles. Minimum is 2 cycles with k=1.
- Back-to-back accesses: the new EX/MEM contents are seen in the IDLE cycle after DONE/ERR. There is therefore one bubble cycle between consecutive accesses.
- mem_ack outside BUSY is ignored and causes no state change.

Test Plan:
- Reset, then load addr=0x100, rd=5, with mem_ack and mem_rdata=0xDEADBEEF_CAFEF00D 3 cycles after mem_req -> mem_req high 3 cycles, mem_we=0, mem_addr=0x100, stall high 4 cycles, then load_valid=1 for 1 cycle with load_data=0xDEADBEEFCAFEF00D and load_rd=5.
- Store addr=0x208, wdata=0x1234, ack after 1 cycle -> mem_we=1, mem_wdata=0x1234, stall high 2 cycles, load_valid stays 0.
- Load addr=0x103 -> mem_req never rises, stall=1 for 1 cycle, misalign_err=1 for 1 cycle, then IDLE.
- TIMEOUT=4, load with no ack -> mem_req high 4 cycles then drops, timeout_err pulses once, stall low on the ERR cycle. A late ack in IDLE produces no load_valid.
- Assert reset during BUSY, then drive mem_ack -> mem_req=0 the cycle after reset, busy=0, no load_valid.
- Two consecutive stores with mem_read=mem_write=1 on the first -> the first issues with mem_we=1; the second is detected in the IDLE cycle after DONE; exactly two mem_req episodes occur.
